// File: rtl/mac_sequencer.sv
// Control sequencer for the MultAccumulate datapath. It walks the result matrix one column pair at a time.
// Defining MAC_SEQ_PERF_COUNT_EN adds a saturating cycle_count output that counts busy cycles.
module mac_sequencer #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_WORDS    = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  clear,
  output logic                  enable_mult,
  output logic                  enable_sum,
  output logic [ADDR_WIDTH-1:0] roma_addr_a,
  output logic [ADDR_WIDTH-1:0] roma_addr_b,
  output logic [ADDR_WIDTH-1:0] romb_addr_a,
  output logic [ADDR_WIDTH-1:0] romb_addr_b,
  output logic [ADDR_WIDTH-1:0] romc_addr_a,
  output logic [ADDR_WIDTH-1:0] romc_addr_b,
  output logic                  result_wr_en,
  output logic [ADDR_WIDTH-1:0] result_wr_addr_a,
  output logic [ADDR_WIDTH-1:0] result_wr_addr_b
`ifdef MAC_SEQ_PERF_COUNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  generate
    if ((COLS < 2) || ((COLS % 2) != 0)) begin : g_colsCheck
      $error("mac_sequencer: COLS must be even and at least 2");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] KW     = ADDR_WIDTH'(K_WORDS);
  localparam logic [ADDR_WIDTH-1:0] CW     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(K_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(COLS - 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_SUM, S_WAIT1, S_WAIT2, S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_i, r_j, r_k;
  logic [ADDR_WIDTH-1:0] w_i, w_j, w_k;
  logic [ADDR_WIDTH-1:0] w_romA, w_romB, w_bias;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state;
      r_i     <= w_i;
      r_j     <= w_j;
      r_k     <= w_k;
    end
  end

  // WAIT1/WAIT2 let the datapath's 2-cycle control pipeline drain before the write and the next clear.
  always_comb begin
    w_state = r_state;
    w_i     = r_i;
    w_j     = r_j;
    w_k     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_CLEAR;
          w_i     = '0;
          w_j     = '0;
          w_k     = '0;
        end
      end
      S_CLEAR: begin
        w_state = S_MAC;
        w_k     = '0;
      end
      S_MAC: begin
        if (r_k == LAST_K) w_state = S_SUM;
        else               w_k     = r_k + 1'b1;
      end
      S_SUM:   w_state = S_WAIT1;
      S_WAIT1: w_state = S_WAIT2;
      S_WAIT2: begin
        if ((r_j == LAST_J) && (r_i == LAST_I)) begin
          w_state = S_DONE;
        end else begin
          w_state = S_CLEAR;
          w_k     = '0;
          if (r_j == LAST_J) begin
            w_j = '0;
            w_i = r_i + 1'b1;
          end else begin
            w_j = r_j + 2'd2;
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign w_romA = (w_i * KW) + w_k;
  assign w_romB = (w_j * KW) + w_k;
  assign w_bias = (w_i * CW) + w_j;

  // Outputs are registered from the next state so each one lines up with the state it belongs to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      clear            <= 1'b0;
      enable_mult      <= 1'b0;
      enable_sum       <= 1'b0;
      result_wr_en     <= 1'b0;
      roma_addr_a      <= '0;
      roma_addr_b      <= '0;
      romb_addr_a      <= '0;
      romb_addr_b      <= '0;
      romc_addr_a      <= '0;
      romc_addr_b      <= '0;
      result_wr_addr_a <= '0;
      result_wr_addr_b <= '0;
    end else begin
      busy             <= (w_state != S_IDLE) && (w_state != S_DONE);
      done             <= (w_state == S_DONE);
      clear            <= (w_state == S_CLEAR);
      enable_mult      <= (w_state == S_MAC);
      enable_sum       <= (w_state == S_SUM);
      result_wr_en     <= (w_state == S_WAIT2);
      roma_addr_a      <= w_romA;
      roma_addr_b      <= w_romA;
      romb_addr_a      <= w_romB;
      romb_addr_b      <= w_romB + KW;
      romc_addr_a      <= w_bias;
      romc_addr_b      <= w_bias + 1'b1;
      result_wr_addr_a <= w_bias;
      result_wr_addr_b <= w_bias + 1'b1;
    end
  end

`ifdef MAC_SEQ_PERF_COUNT_EN
  // The accepting cycle is counted as the first one, so the count lands on busy cycles plus one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      cycle_count <= 32'd1;
    end else if (busy && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule
